// File: rtl/spi_xip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_xip_pkg
// Description : Shared types and constants for the APB SPI XIP bridge:
//               controller state encoding, flash READ opcode, maximum frame
//               length and a byte-swap helper for little-endian assembly.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_xip_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CS_HOLD = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;

    // Longest frame: 8 command bits + 32 address bits + 32 data bits.
    localparam int FRAME_MAX = 72;

    // First received byte sits in [31:24]; move it to [7:0].
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_xip_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_xip_shifter
// Description : SPI mode-0 serialiser. Loads a left-aligned frame on start,
//               samples MISO on rising SCK, advances MOSI on falling SCK.
//               Each SCK half-period lasts SCK_DIV clocks.
// Ports       : clock, reset      - clock, synchronous active-high reset
//               start, frame      - load frame (MSB first) and begin
//               length            - number of SCK cycles in the frame
//               miso              - serial input
//               sck, mosi         - serial clock (idle low) and data out
//               rx                - last 32 bits received
//               done              - high in the cycle of the final falling edge
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xip_shifter
    import spi_xip_pkg::*;
#(
    parameter int SCK_DIV = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [FRAME_MAX-1:0] frame,
    input  logic [6:0]           length,
    input  logic                 miso,
    output logic                 sck,
    output logic                 mosi,
    output logic [31:0]          rx,
    output logic                 done
);

    localparam int              DIV_W    = $clog2(SCK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

    logic                 r_busy;
    logic                 r_sck;
    logic [DIV_W-1:0]     r_div;
    logic [6:0]           r_bits;
    logic [6:0]           r_len;
    logic [FRAME_MAX-1:0] r_shift;
    logic [31:0]          r_rx;

    logic w_tick;
    logic w_rise;
    logic w_fall;

    assign w_tick = r_busy && (r_div == DIV_LAST);
    assign w_rise = w_tick && !r_sck;
    assign w_fall = w_tick && r_sck;
    // Combinational so the controller leaves SHIFT on the same edge as the
    // last falling SCK edge.
    assign done   = w_fall && (r_bits == (r_len - 7'd1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_sck   <= 1'b0;
            r_div   <= '0;
            r_bits  <= '0;
            r_len   <= '0;
            r_shift <= '0;
            r_rx    <= '0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_sck   <= 1'b0;
            r_div   <= '0;
            r_bits  <= '0;
            r_len   <= length;
            r_shift <= frame;
        end else if (r_busy) begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_rise) begin
                r_sck <= 1'b1;
                r_rx  <= {r_rx[30:0], miso};
            end
            if (w_fall) begin
                r_sck   <= 1'b0;
                r_shift <= {r_shift[FRAME_MAX-2:0], 1'b0};
                r_bits  <= r_bits + 7'd1;
                if (done) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign sck  = r_sck;
    assign mosi = r_busy & r_shift[FRAME_MAX-1];
    assign rx   = r_rx;

endmodule
`default_nettype wire

// File: rtl/spi_xip_apb.sv
`default_nettype none
// ============================================================================
// Module      : spi_xip_apb
// Description : APB execute-in-place bridge. APB reads inside the flash
//               window become SPI READ frames (mode 0); one word is cached.
//               Writes and window misses complete with pslverr.
// Ports       : clock, reset                     - clock, sync active-high reset
//               in_paddr/psel/penable/pwrite     - APB request
//               in_pprot/in_pwdata/in_pstrb      - ignored
//               in_pready/in_prdata/in_pslverr   - APB response
//               xip_flush                        - cache invalidate pulse
//               spi_sck/spi_ss/spi_mosi/spi_miso - SPI flash pins
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xip_apb
    import spi_xip_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE    = 32'h3000_0000,
    parameter logic [31:0] FLASH_MASK    = 32'h0FFF_FFFF,
    parameter int          ADDR_BITS     = 24,
    parameter logic [7:0]  READ_CMD      = FLASH_CMD_READ,
    parameter int          SCK_DIV       = 1,
    parameter int          SS_NUM        = 8,
    parameter int          SS_IDX        = 0,
    parameter bit          LITTLE_ENDIAN = 1'b1,
    parameter bit          CACHE_EN      = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic              in_pwrite,
    input  logic [2:0]        in_pprot,
    input  logic [31:0]       in_pwdata,
    input  logic [3:0]        in_pstrb,
    output logic              in_pready,
    output logic [31:0]       in_prdata,
    output logic              in_pslverr,
    input  logic              xip_flush,
    output logic              spi_sck,
    output logic [SS_NUM-1:0] spi_ss,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int TAG_W     = ADDR_BITS - 2;
    localparam int FRAME_LEN = 8 + ADDR_BITS + 32;

    state_t r_state;
    state_t w_next;

    logic             r_valid;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_data;
    logic             r_err;
    logic             r_ss_n;
    logic             r_flush_seen;

    logic                 w_access;
    logic                 w_in_window;
    logic                 w_bad;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_hit;
    logic                 w_start;
    logic                 w_done;
    logic [31:0]          w_rx;
    logic [FRAME_MAX-1:0] w_frame;
    logic                 w_unused;

    assign w_access    = in_psel & in_penable;
    assign w_in_window = (in_paddr & ~FLASH_MASK) == FLASH_BASE;
    assign w_bad       = in_pwrite | ~w_in_window;
    assign w_tag       = in_paddr[ADDR_BITS-1:2];
    // A flush in the decision cycle forces a miss.
    assign w_hit       = CACHE_EN && r_valid && !xip_flush && (r_tag == w_tag);
    // Left-aligned frame; address bits [1:0] are forced to zero and the
    // trailing zeros keep MOSI low during the data phase.
    assign w_frame     = {READ_CMD, w_tag, 2'b00,
                          {(FRAME_MAX - 8 - ADDR_BITS){1'b0}}};
    assign w_unused    = ^{in_pprot, in_pwdata, in_pstrb, in_paddr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_bad || w_hit) begin
                        w_next = RESP;
                    end else begin
                        w_next  = SHIFT;
                        w_start = 1'b1;
                    end
                end
            end
            SHIFT:   if (w_done) w_next = CS_HOLD;
            CS_HOLD: w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_tag        <= '0;
            r_data       <= '0;
            r_err        <= 1'b0;
            r_ss_n       <= 1'b1;
            r_flush_seen <= 1'b0;
        end else begin
            r_ss_n <= (w_next != SHIFT);
            if (r_state == IDLE && w_access) begin
                r_err <= w_bad;
            end
            if (w_start) begin
                r_tag        <= w_tag;
                r_flush_seen <= 1'b0;
            end else if (xip_flush) begin
                r_flush_seen <= 1'b1;
            end
            if (r_state == CS_HOLD) begin
                r_data <= LITTLE_ENDIAN ? bswap32(w_rx) : w_rx;
            end
            // The tag changes at fetch start, so the old entry must die then.
            if (xip_flush || w_start) begin
                r_valid <= 1'b0;
            end else if (r_state == CS_HOLD && !r_flush_seen) begin
                r_valid <= 1'b1;
            end
        end
    end

    spi_xip_shifter #(
        .SCK_DIV (SCK_DIV)
    ) u_shifter (
        .clock  (clock),
        .reset  (reset),
        .start  (w_start),
        .frame  (w_frame),
        .length (7'(FRAME_LEN)),
        .miso   (spi_miso),
        .sck    (spi_sck),
        .mosi   (spi_mosi),
        .rx     (w_rx),
        .done   (w_done)
    );

    for (genvar i = 0; i < SS_NUM; i++) begin : g_ss
        if (i == SS_IDX) begin : g_sel
            assign spi_ss[i] = r_ss_n;
        end else begin : g_idle
            assign spi_ss[i] = 1'b1;
        end
    end

    assign in_pready  = (r_state == RESP);
    assign in_pslverr = in_pready & r_err;
    assign in_prdata  = (in_pready && !r_err) ? r_data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_spi_xip_apb.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xip_apb
// Description : Scoreboard bench for spi_xip_apb. Instance 0 uses defaults;
//               instance 1 uses SCK_DIV=3, big-endian, 32-bit address,
//               select line 2. A flash model returns bytes 11 22 33 44.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xip_apb;

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic        err;
        int          start;
        int          lat;
        logic        miss;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] paddr;
    logic        pwrite;
    logic [1:0]  psel;
    logic [1:0]  penable;
    logic        xip_flush;
    logic [1:0]  pready;
    logic [1:0]  pslverr;
    logic [31:0] prdata [2];
    logic [1:0]  sck;
    logic [1:0]  mosi;
    logic [1:0]  miso = 2'b00;
    logic [7:0]  ss [2];

    int   cyc = 0;
    int   compared = 0;
    int   fails = 0;
    exp_t sb[$];

    int          total_rises [2] = '{0, 0};
    int          frame_rises [2] = '{0, 0};
    int          falls       [2] = '{0, 0};
    int          last_rise   [2] = '{-1, -1};
    int          bad         [2] = '{0, 0};
    int          ss_rise_cyc [2] = '{0, 0};
    logic [71:0] cap         [2];
    logic [1:0]  prev_sck = 2'b00;
    logic [1:0]  prev_ssl = 2'b11;
    logic [31:0] flash_word = 32'h1122_3344;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_xip_apb u_dut0 (
        .clock(clk), .reset(reset), .in_paddr(paddr), .in_psel(psel[0]),
        .in_penable(penable[0]), .in_pwrite(pwrite), .in_pprot(3'b000),
        .in_pwdata(32'h0), .in_pstrb(4'h0), .in_pready(pready[0]),
        .in_prdata(prdata[0]), .in_pslverr(pslverr[0]), .xip_flush(xip_flush),
        .spi_sck(sck[0]), .spi_ss(ss[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
    );

    spi_xip_apb #(
        .ADDR_BITS(32), .SCK_DIV(3), .SS_IDX(2), .LITTLE_ENDIAN(1'b0)
    ) u_dut1 (
        .clock(clk), .reset(reset), .in_paddr(paddr), .in_psel(psel[1]),
        .in_penable(penable[1]), .in_pwrite(pwrite), .in_pprot(3'b000),
        .in_pwdata(32'h0), .in_pstrb(4'h0), .in_pready(pready[1]),
        .in_prdata(prdata[1]), .in_pslverr(pslverr[1]), .xip_flush(xip_flush),
        .spi_sck(sck[1]), .spi_ss(ss[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
    );

    function automatic int abits(input int i);
        return (i == 1) ? 32 : 24;
    endfunction
    function automatic int divs(input int i);
        return (i == 1) ? 3 : 1;
    endfunction
    function automatic int ssidx(input int i);
        return (i == 1) ? 2 : 0;
    endfunction
    function automatic logic [7:0] ss_active(input int i);
        return (i == 1) ? 8'hFB : 8'hFE;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        compared++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Flash model: sees SCK edges on the falling clock, samples MOSI on
    // rising SCK, presents the next data bit after each falling SCK.
    always @(negedge clk) begin
        logic ssl;
        int   j;
        for (int i = 0; i < 2; i++) begin
            ssl = ss[i][ssidx(i)];
            if (!ssl && prev_ssl[i]) begin
                frame_rises[i] = 0;
                falls[i]       = 0;
                last_rise[i]   = -1;
            end
            if (ssl && !prev_ssl[i]) ss_rise_cyc[i] = cyc;
            if (sck[i] && !prev_sck[i]) begin
                total_rises[i]++;
                frame_rises[i]++;
                cap[i] = {cap[i][70:0], mosi[i]};
                if (last_rise[i] >= 0 && (cyc - last_rise[i]) != 2 * divs(i)) bad[i]++;
                if (ss[i] != ss_active(i)) bad[i]++;
                last_rise[i] = cyc;
            end
            if (!sck[i] && prev_sck[i]) begin
                falls[i]++;
                j = falls[i] - (8 + abits(i));
                miso[i] = (j >= 0 && j < 32) ? flash_word[31 - j] : 1'b0;
            end
            prev_sck[i] = sck[i];
            prev_ssl[i] = ssl;
        end
    end

    // Scoreboard monitor: pops an expectation whenever a DUT signals pready.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (pready[i]) begin
                if (sb.size() == 0) begin
                    compared++;
                    fails++;
                    $display("FAIL unexpected_pready inst%0d: got pready 1 required 0", i);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("inst%0d_owner", i), 72'(i), 72'(e.inst));
                    check($sformatf("inst%0d_prdata", i), 72'(prdata[i]), 72'(e.data));
                    check($sformatf("inst%0d_pslverr", i), 72'(pslverr[i]), 72'(e.err));
                    check($sformatf("inst%0d_latency", i), 72'(cyc - e.start), 72'(e.lat));
                    if (e.miss)
                        check($sformatf("inst%0d_ss_rise_before_pready", i),
                              72'(ss_rise_cyc[i]), 72'(cyc - 1));
                end
            end
        end
    end

    task automatic apb_xfer(input int inst, input logic [31:0] addr, input logic wr,
                            input logic [31:0] d, input logic e, input int lat,
                            input logic miss);
        exp_t x;
        int   n;
        @(negedge clk);
        paddr = addr; pwrite = wr; psel[inst] = 1'b1; penable[inst] = 1'b0;
        @(negedge clk);
        penable[inst] = 1'b1;
        x.inst = inst; x.data = d; x.err = e; x.start = cyc; x.lat = lat; x.miss = miss;
        sb.push_back(x);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pready[inst] && n < 3000);
        if (!pready[inst]) begin
            compared++;
            fails++;
            $display("FAIL apb_timeout inst%0d: got no pready required pready", inst);
            void'(sb.pop_back());
        end
        psel[inst] = 1'b0; penable[inst] = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        int t0;
        int n;
        reset = 1'b1; paddr = '0; pwrite = 1'b0; psel = '0; penable = '0; xip_flush = 1'b0;
        cap[0] = '0; cap[1] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_pready%0d", i), 72'(pready[i]), 72'd0);
            check($sformatf("rst_pslverr%0d", i), 72'(pslverr[i]), 72'd0);
            check($sformatf("rst_prdata%0d", i), 72'(prdata[i]), 72'd0);
            check($sformatf("rst_sck%0d", i), 72'(sck[i]), 72'd0);
            check($sformatf("rst_ss%0d", i), 72'(ss[i]), 72'hFF);
            check($sformatf("rst_mosi%0d", i), 72'(mosi[i]), 72'd0);
        end
        reset = 1'b0;

        // Cold read: full frame, little-endian assembly.
        apb_xfer(0, 32'h3000_0004, 1'b0, 32'h4433_2211, 1'b0, 130, 1'b1);
        check("miss_sck_count", 72'(frame_rises[0]), 72'd64);
        check("miss_mosi_frame", 72'(cap[0][63:0]), 72'h0300_0004_0000_0000);

        // Cached repeat: no SCK activity, one wait state.
        t0 = total_rises[0];
        apb_xfer(0, 32'h3000_0004, 1'b0, 32'h4433_2211, 1'b0, 1, 1'b0);
        check("hit_no_sck", 72'(total_rises[0] - t0), 72'd0);

        // Flush forces a refetch.
        @(negedge clk); xip_flush = 1'b1;
        @(negedge clk); xip_flush = 1'b0;
        t0 = total_rises[0];
        apb_xfer(0, 32'h3000_0004, 1'b0, 32'h4433_2211, 1'b0, 130, 1'b1);
        check("flush_refetch_sck", 72'(total_rises[0] - t0), 72'd64);

        // Write and out-of-window read are errors with no SPI traffic.
        t0 = total_rises[0];
        apb_xfer(0, 32'h3000_0000, 1'b1, 32'h0, 1'b1, 1, 1'b0);
        apb_xfer(0, 32'h1000_0000, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        check("err_no_sck", 72'(total_rises[0] - t0), 72'd0);

        // Slow divider, big-endian, 32-bit address, select line 2.
        apb_xfer(1, 32'h3000_0010, 1'b0, 32'h1122_3344, 1'b0, 434, 1'b1);
        check("div3_sck_count", 72'(frame_rises[1]), 72'd72);
        check("div3_mosi_frame", cap[1], 72'h03_3000_0010_0000_0000);
        check("div3_period_and_ss", 72'(bad[1]), 72'd0);
        apb_xfer(1, 32'h3000_0010, 1'b0, 32'h1122_3344, 1'b0, 1, 1'b0);

        // Reset in the middle of a fetch aborts it silently.
        @(negedge clk); paddr = 32'h3000_0008; psel[0] = 1'b1;
        @(negedge clk); penable[0] = 1'b1;
        n = 0;
        while (frame_rises[0] < 20 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_bit20", 72'(frame_rises[0] >= 20), 72'd1);
        reset = 1'b1; psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        check("abort_ss", 72'(ss[0]), 72'hFF);
        check("abort_sck", 72'(sck[0]), 72'd0);
        check("abort_pready", 72'(pready[0]), 72'd0);
        reset = 1'b0;
        apb_xfer(0, 32'h3000_0008, 1'b0, 32'h4433_2211, 1'b0, 130, 1'b1);
        check("after_abort_mosi_frame", 72'(cap[0][63:0]), 72'h0300_0008_0000_0000);
        check("div1_period_and_ss", 72'(bad[0]), 72'd0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 72'(sb.size()), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/spi_xip_apb.md
# spi_xip_apb

Parametrised APB execute-in-place (XIP) bridge that turns APB reads in a flash window into SPI flash READ transactions. It drives the SPI pins directly in mode 0, with no intermediate Wishbone SPI master. It adds configurable address width, clock divider, chip-select index and byte order, a one-word fetch cache with flush, and error responses. It sits on the APB peripheral crossbar in front of the SPI NOR flash.

## Interface
- FLASH_BASE, 32'h3000_0000: window start.
- FLASH_MASK, 32'h0FFF_FFFF: window offset mask; hit = (paddr & ~FLASH_MASK) == FLASH_BASE.
- ADDR_BITS, 24: flash address bits sent; legal values 24 or 32.
- READ_CMD, 8'h03: command byte.
- SCK_DIV, 1: clocks per SCK half-period, ≥1.
- SS_NUM, 8: chip-select width.
- SS_IDX, 0: select line used.
- LITTLE_ENDIAN, 1: 1 = first flash byte to prdata[7:0]; 0 = first byte to prdata[31:24].
- CACHE_EN, 1: enable one-word cache.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- in_paddr  in  32  APB address.
- in_psel, in_penable, in_pwrite  in  1  APB control.
- in_pprot  in  3  ignored.
- in_pwdata  in  32  ignored.
- in_pstrb  in  4  ignored.
- in_pready  out  1  transfer done.
- in_prdata  out  32  read data.
- in_pslverr  out  1  error.
- xip_flush  in  1  one-cycle pulse that invalidates the cache.
- spi_sck  out  1  SPI clock, idle low.
- spi_ss  out  SS_NUM  active-low selects.
- spi_mosi  out  1  serial out.
- spi_miso  in  1  serial in.

## Operation
- States:
  - IDLE: wait for a request.
  - SHIFT: serial transfer in progress.
  - CS_HOLD: select released.
  - RESP: APB response.
- IDLE → RESP with pslverr=1 when the access phase (psel&penable) is a write or a window miss.
- IDLE → RESP with pslverr=0 on a cache hit: CACHE_EN, valid, tag == paddr[ADDR_BITS-1:2].
- IDLE → SHIFT otherwise.
  - Load shift word {READ_CMD, paddr[ADDR_BITS-1:2], 2'b00}; address bits [1:0] are always sent as 0, so fetches are word-aligned.
  - Drop spi_ss[SS_IDX] and drive MOSI with the command MSB in the same edge.
- SHIFT, frame length N = 8 + ADDR_BITS + 32 bits.
  - Each half-period lasts SCK_DIV clocks.
  - Rising SCK: sample MISO.
  - Falling SCK: advance MOSI, MSB first.
  - MOSI is 0 during the 32 data bits.
  - After the N-th falling edge → CS_HOLD.
- CS_HOLD: one clock with ss high and sck low.
  - Assemble the 4 received bytes per LITTLE_ENDIAN into the data register.
  - Install the cache entry (valid=1, tag) unless xip_flush was seen during the fetch.
  - → RESP.
- RESP: pready=1 for exactly one clock; prdata and pslverr are valid only in this cycle, and prdata=0 on error. → IDLE.
- xip_flush clears valid in any state. A flush at the same cycle as a hit decision wins, and the access is treated as a miss.
- Other outputs: in_pprot and in_pwdata are ignored; SS lines other than SS_IDX are always 1.

## Timing
- Reset values:
  - state IDLE, cache valid=0.
  - in_pready, in_pslverr, in_prdata all 0.
  - spi_sck=0, spi_ss all ones, spi_mosi=0.
- Reset mid-transfer aborts within one clock: ss rises and no APB response is issued.
- Miss latency from the first access-phase cycle to pready: 2·SCK_DIV·N + 2 clocks. With defaults this is 130.
- Hit or error latency: pready in the 2nd access-phase cycle (1 wait state).
- APB rules:
  - The master holds paddr, psel and penable until pready.
  - The setup phase (psel & !penable) starts nothing.
  - Back-to-back transfers are allowed: IDLE accepts the next access phase the cycle after RESP.
- Counters:
  - Bit counter is 7 bits wide: 72 max.
  - Divider counter is clog2(SCK_DIV)+1 bits wide; it wraps to 0 at SCK_DIV-1 and then toggles SCK.

## Structure
- Package spi_xip_pkg: state enum (IDLE, SHIFT, CS_HOLD, RESP) and FLASH_CMD_READ = 8'h03.
- Sub-module spi_xip_shifter, mode-0 serialiser:
  - Inputs: start, frame word, length.
  - Outputs: sck, mosi, 32-bit rx word, done pulse.
  - Owns the divider and bit counters.
- Top level owns the APB decode, cache and FSM.

## Test plan
- Reset, then read 0x3000_0004, flash bytes 11 22 33 44:
  - MOSI carries 0x03, 0x000004.
  - prdata=0x44332211 after 130 clocks.
  - ss rises before pready.
- Repeat the read of 0x3000_0004: no SCK edges, pready in the 2nd access cycle, same data.
- Pulse xip_flush, then read 0x3000_0004: a full SPI frame occurs again.
- APB write to 0x3000_0000 and read of 0x1000_0000: pslverr=1, prdata=0, no SPI activity.
- SCK_DIV=3, LITTLE_ENDIAN=0, ADDR_BITS=32, read 0x3000_0010:
  - 72 SCK cycles of 6 clocks each.
  - 32-bit address 0x3000_0010 on MOSI.
  - prdata=0x11223344.
- Assert reset at bit 20 of a fetch: next cycle ss all ones, sck=0, no pready; a following read completes normally.
